// File: rtl/picoramsoc_timer_if.sv
// Bus bundle for the picoramsoc iomem port as seen by one peripheral.
// The SoC side drives the request; the peripheral returns a one-cycle
// ready pulse together with the read data.
interface picoramsoc_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/picoramsoc_timer.sv
// Memory-mapped 32-bit countdown timer with 16-bit prescaler for the
// picoramsoc iomem bus. Supports one-shot and periodic operation and
// raises a level interrupt (pending & irq_en) for the SoC's irq_5 line.
//
// Register map (offset = addr[4:2]):
//   0 CTRL     {irq_en, auto_reload, enable}
//   1 LOAD     reload value; writing it also restarts COUNT
//   2 COUNT    current count
//   3 STATUS   {pending}, write 1 to clear
//   4 PRESCALE cycles per tick minus one
//   5-7        read 0, writes ignored
module picoramsoc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  picoramsoc_timer_if.slave    bus,
  output logic                 irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // Architectural state
  logic        enable_q;
  logic        auto_reload_q;
  logic        irq_en_q;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        pending_q;
  logic [15:0] prescale_q;
  logic [15:0] pscnt_q;

  // Bus response registers
  logic        ready_q;
  logic [31:0] rdata_q;

  // Decode and strobe qualification
  logic        hit;
  logic        sel;
  logic        wr;
  logic [2:0]  off;
  logic [3:0]  strb;
  logic [31:0] wdata;

  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status_clr;
  logic        wr_prescale;
  logic        ctrl_stop;

  logic        tick_raw;
  logic        tick;

  logic [31:0] load_nxt;
  logic [31:0] count_nxt;
  logic [31:0] rd_val;

  // Replace the byte lanes selected by strb, keep the others.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  assign off   = bus.iomem_addr[4:2];
  assign strb  = bus.iomem_wstrb;
  assign wdata = bus.iomem_wdata;

  // Only the upper address bits select the block; ready blocks a second
  // response while the master still holds valid after the first one.
  assign hit = (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign sel = bus.iomem_valid && hit && !ready_q;
  assign wr  = sel && (strb != 4'b0000);

  assign wr_ctrl       = wr && (off == OFF_CTRL) && strb[0];
  assign wr_load       = wr && (off == OFF_LOAD);
  assign wr_count      = wr && (off == OFF_COUNT);
  assign wr_status_clr = wr && (off == OFF_STATUS) && strb[0] && wdata[0];
  assign wr_prescale   = wr && (off == OFF_PRESCALE);
  assign ctrl_stop     = wr_ctrl && !wdata[0];

  assign load_nxt  = merge_bytes(load_q, wdata, strb);
  assign count_nxt = merge_bytes(count_q, wdata, strb);

  // A PRESCALE lowered below the running prescale count ticks at once
  // rather than wrapping through the full 16-bit range.
  assign tick_raw = enable_q && (pscnt_q >= prescale_q);

  // A bus write to LOAD/COUNT, or one that stops the timer, owns this edge:
  // the coincident tick is dropped entirely (no decrement, no expiry).
  assign tick = tick_raw && !ctrl_stop && !wr_load && !wr_count;

  // Read mux returns the register value as it was before this edge
  always_comb begin
    rd_val = 32'h0;
    case (off)
      OFF_CTRL:     rd_val = {29'd0, irq_en_q, auto_reload_q, enable_q};
      OFF_LOAD:     rd_val = load_q;
      OFF_COUNT:    rd_val = count_q;
      OFF_STATUS:   rd_val = {31'd0, pending_q};
      OFF_PRESCALE: rd_val = {16'd0, prescale_q};
      default:      rd_val = 32'h0;
    endcase
  end

  // One-cycle response pulse; rdata is forced to zero outside the pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= sel;
      rdata_q <= sel ? rd_val : 32'h0;
    end
  end

  // Prescale counter: free-runs while enabled, restarts on tick or reload
  always_ff @(posedge clk) begin
    if (reset) begin
      pscnt_q <= 16'd0;
    end else if (!enable_q || tick_raw || wr_load || ctrl_stop) begin
      pscnt_q <= 16'd0;
    end else begin
      pscnt_q <= pscnt_q + 16'd1;
    end
  end

  // Timer registers: tick effects first, bus writes last so the bus wins
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q      <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      load_q        <= 32'h0;
      count_q       <= 32'h0;
      pending_q     <= 1'b0;
      prescale_q    <= 16'h0;
    end else begin
      // Clear is applied before the expiry check so a coincident expiry
      // leaves pending set.
      if (wr_status_clr) pending_q <= 1'b0;

      if (tick) begin
        if (count_q > 32'd1) begin
          count_q <= count_q - 32'd1;
        end else if (count_q == 32'd1) begin
          pending_q <= 1'b1;
          if (auto_reload_q) begin
            count_q <= load_q;
          end else begin
            count_q  <= 32'h0;
            enable_q <= 1'b0;
          end
        end else begin
          // Enabled without ever being loaded: stop quietly.
          enable_q <= 1'b0;
        end
      end

      if (wr_ctrl) begin
        enable_q      <= wdata[0];
        auto_reload_q <= wdata[1];
        irq_en_q      <= wdata[2];
      end

      if (wr_load) begin
        load_q  <= load_nxt;
        count_q <= load_nxt;
      end

      if (wr_count) count_q <= count_nxt;

      if (wr_prescale) begin
        if (strb[0]) prescale_q[7:0]  <= wdata[7:0];
        if (strb[1]) prescale_q[15:8] <= wdata[15:8];
      end
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq             = pending_q & irq_en_q;

endmodule

// File: tb/tb_picoramsoc_timer.sv
// Scoreboard bench for picoramsoc_timer. The driver predicts each response
// from an arithmetic model of the timer (ticks elapsed since enable, expiry
// edges as multiples of LOAD*(PRESCALE+1)) and queues it; a monitor pops and
// compares whenever the DUT raises iomem_ready.
module tb_picoramsoc_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;

  picoramsoc_timer_if bus();

  picoramsoc_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_load;
  logic [31:0] m_cnt_static;
  logic [15:0] m_pre;
  logic        m_auto;
  logic        m_irqen;
  int          m_E;     // edge at which enable was accepted, -1 if idle
  int          m_clr;   // edge of most recent pending clear, -1 if none

  function automatic void model_reset();
    m_load = '0; m_cnt_static = '0; m_pre = '0;
    m_auto = 1'b0; m_irqen = 1'b0; m_E = -1; m_clr = -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Timer state after edge n
  function automatic void model_at(input int n, output logic [31:0] cnt,
                                   output logic en, output logic pend);
    int L, D, t, x;
    bit has;
    has = 0; x = 0;
    if (m_E < 0 || n < m_E) begin
      cnt = m_cnt_static; en = 1'b0; pend = 1'b0;
      return;
    end
    L = int'(m_load);
    D = int'(m_pre) + 1;
    t = (n - m_E) / D;
    if (m_auto) begin
      cnt = 32'(L - (t % L));
      en  = 1'b1;
      if (t >= L) begin has = 1; x = m_E + (t / L) * L * D; end
    end else if (t >= L) begin
      cnt = 32'h0; en = 1'b0; has = 1; x = m_E + L * D;
    end else begin
      cnt = 32'(L - t); en = 1'b1;
    end
    pend = has && (x >= m_clr);
  endfunction

  function automatic logic [31:0] model_reg(input logic [2:0] off, input int n);
    logic [31:0] c;
    logic e, p;
    model_at(n, c, e, p);
    case (off)
      3'd0:    return {29'd0, m_irqen, m_auto, e};
      3'd1:    return m_load;
      3'd2:    return c;
      3'd3:    return {31'd0, p};
      3'd4:    return {16'd0, m_pre};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq(input int n);
    logic [31:0] c;
    logic e, p;
    model_at(n, c, e, p);
    return p & m_irqen;
  endfunction

  function automatic void model_write(input logic [2:0] off, input logic [3:0] st,
                                      input logic [31:0] wd, input int a);
    logic [31:0] tmp;
    case (off)
      3'd0: if (st[0]) begin
        m_irqen = wd[2]; m_auto = wd[1]; m_E = wd[0] ? a : -1;
      end
      3'd1: begin m_load = merge(m_load, wd, st); m_cnt_static = m_load; end
      3'd2: m_cnt_static = merge(m_cnt_static, wd, st);
      3'd3: if (st[0] && wd[0]) m_clr = a;
      3'd4: begin tmp = merge({16'h0, m_pre}, wd, {2'b00, st[1:0]}); m_pre = tmp[15:0]; end
      default: ;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    logic [31:0] data;
    int          acc_n;
    logic        irq_v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   last_acc;

  always @(negedge clk) begin
    if (bus.iomem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 at cycle %0d, expected no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_rdata"}, bus.iomem_rdata, mon_e.data);
        chk({mon_e.tag, "_latency"}, 32'(cyc), 32'(mon_e.acc_n));
        chk({mon_e.tag, "_irq"}, {31'd0, irq}, {31'd0, mon_e.irq_v});
      end
    end else if (!reset) begin
      chk("rdata_idle", bus.iomem_rdata, 32'h0);
    end
  end

  // ---------------- driver ----------------
  task automatic xfer_at(input int acc, input logic [2:0] off, input logic [3:0] st,
                         input logic [31:0] wd, input string tag);
    exp_t e;
    int n;
    while (cyc < acc - 1) begin @(posedge clk); #1; end
    n       = cyc;
    e.tag   = tag;
    e.acc_n = n + 1;
    e.data  = model_reg(off, n);
    if (st != 4'b0000) model_write(off, st, wd, n + 1);
    e.irq_v = model_irq(n + 1);
    sb.push_back(e);
    last_acc = n + 1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = BASE | {27'd0, off, 2'b00};
    bus.iomem_wstrb = st;
    bus.iomem_wdata = wd;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic [2:0] off, input logic [3:0] st,
                      input logic [31:0] wd, input string tag);
    xfer_at(cyc + 1, off, st, wd, tag);
  endtask

  task automatic rd(input logic [2:0] off, input string tag);
    xfer(off, 4'b0000, 32'h0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, bus.iomem_ready}, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  int E;
  int g;
  int r;
  logic [31:0] wd;

  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_wdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset in the middle of a running count
    xfer(3'd1, 4'hF, 32'h10, "t1_load");
    xfer(3'd0, 4'h1, 32'h1, "t1_ctrl");
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 5; i++) rd(3'(i), "t1_rst_rd");

    // Periodic, PRESCALE=0, LOAD=5; clear coinciding with expiry keeps pending
    xfer(3'd1, 4'hF, 32'd5, "t2_load");
    xfer(3'd0, 4'h1, 32'h7, "t2_ctrl");
    E = last_acc;
    xfer_at(E + 3,  3'd3, 4'h0, 32'h0, "t2_status");
    xfer_at(E + 5,  3'd2, 4'h0, 32'h0, "t2_count");
    xfer_at(E + 7,  3'd2, 4'h0, 32'h0, "t2_reload");
    xfer_at(E + 9,  3'd3, 4'h1, 32'h1, "t2_w1c");
    xfer_at(E + 11, 3'd3, 4'h0, 32'h0, "t2_second");
    xfer_at(E + 13, 3'd3, 4'h1, 32'h1, "t2_w1c2");
    xfer_at(E + 15, 3'd3, 4'h1, 32'h1, "t2_w1c_on_expiry");
    xfer_at(E + 17, 3'd3, 4'h0, 32'h0, "t2_set_wins");

    // One-shot
    do_reset();
    xfer(3'd1, 4'hF, 32'd3, "t3_load");
    xfer(3'd0, 4'h1, 32'h5, "t3_ctrl");
    E = last_acc;
    xfer_at(E + 5,  3'd0, 4'h0, 32'h0, "t3_ctrl_rd");
    xfer_at(E + 7,  3'd2, 4'h0, 32'h0, "t3_count");
    xfer_at(E + 9,  3'd3, 4'h0, 32'h0, "t3_status");
    xfer_at(E + 11, 3'd3, 4'h1, 32'h1, "t3_w1c");
    xfer_at(E + 30, 3'd3, 4'h0, 32'h0, "t3_no_rearm");

    // Prescaled periodic: PRESCALE=3, LOAD=2
    do_reset();
    xfer(3'd4, 4'h3, 32'd3, "t4_pre");
    xfer(3'd1, 4'hF, 32'd2, "t4_load");
    xfer(3'd0, 4'h1, 32'h7, "t4_ctrl");
    E = last_acc;
    xfer_at(E + 2,  3'd2, 4'h0, 32'h0, "t4_c0");
    xfer_at(E + 6,  3'd2, 4'h0, 32'h0, "t4_c1");
    xfer_at(E + 10, 3'd2, 4'h0, 32'h0, "t4_c2");
    xfer_at(E + 12, 3'd3, 4'h0, 32'h0, "t4_status");
    xfer_at(E + 14, 3'd2, 4'h0, 32'h0, "t4_c3");

    // Byte strobes and unmapped offsets
    do_reset();
    xfer(3'd1, 4'b0001, 32'hAABB_CCDD, "t5_load_b0");
    rd(3'd1, "t5_load");
    rd(3'd2, "t5_count");
    for (int i = 0; i < 8; i++) begin
      r  = $urandom_range(0, 5);
      wd = $urandom;
      case (r)
        0: xfer(3'd1, 4'($urandom_range(1, 15)), wd, "t5_wload");
        1: xfer(3'd2, 4'($urandom_range(1, 15)), wd, "t5_wcount");
        2: xfer(3'd4, 4'($urandom_range(1, 15)), wd, "t5_wpre");
        default: xfer(3'(r + 2), 4'($urandom_range(1, 15)), wd, "t5_wunmapped");
      endcase
    end
    for (int i = 0; i < 8; i++) rd(3'(i), "t5_rdall");

    // Outside the decode window: no response, no state change
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0004;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("miss_ready", {31'd0, bus.iomem_ready}, 32'h0);
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    rd(3'd1, "t6_load_untouched");

    // Valid held for two cycles yields one response
    begin
      exp_t e;
      e.tag   = "t7_hold2";
      e.acc_n = cyc + 1;
      e.data  = model_reg(3'd1, cyc);
      e.irq_v = model_irq(cyc + 1);
      sb.push_back(e);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = BASE | 32'h4;
      bus.iomem_wstrb = 4'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.iomem_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Randomized timer configurations with random access timing
    for (int it = 0; it < 8; it++) begin
      do_reset();
      xfer(3'd4, 4'b0011, 32'($urandom_range(0, 3)), "r_pre");
      xfer(3'd1, 4'b1111, 32'($urandom_range(1, 6)), "r_load");
      wd = $urandom;
      wd[0] = 1'b1;
      wd[1] = 1'($urandom_range(0, 1));
      wd[2] = ($urandom_range(0, 3) != 0);
      xfer(3'd0, 4'b0001, wd, "r_ctrl");
      for (int j = 0; j < 14; j++) begin
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
        r = $urandom_range(0, 4);
        case (r)
          0: rd(3'd0, "r_ctrl_rd");
          1, 2: rd(3'd2, "r_count");
          3: rd(3'd3, "r_status");
          default: begin
            wd = $urandom;
            wd[0] = 1'b1;
            xfer(3'd3, 4'b0001, wd, "r_w1c");
          end
        endcase
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
